// File: rtl/fifo_flow_ctrl_param.sv
// ============================================================================
// Module      : fifo_flow_ctrl_param
// Description : Parametrised synchronous FIFO with registered read port,
//               sticky overflow/underflow flag and hysteretic PAUSE/CONTINUE
//               flow control. Optional macro FIFO_ERR_CLR_EN adds err_clr.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_flow_ctrl_param #(
    parameter int DATA_W = 6,
    parameter int DEPTH  = 8,
    parameter int ADDR_W = 3,
    parameter int TH_W   = 4
) (
    input  logic              clk,
    input  logic              reset_L,
    input  logic              push,
    input  logic              pop,
`ifdef FIFO_ERR_CLR_EN
    input  logic              err_clr,
`endif
    input  logic [DATA_W-1:0] data_in,
    input  logic [TH_W-1:0]   almost_empty_th,
    input  logic [TH_W-1:0]   almost_full_th,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              pause,
    output logic              continue_o,
    output logic              fifo_error,
    output logic [ADDR_W:0]   occupancy
);

    // Threshold arithmetic is done one bit wider than either operand so that
    // occupancy + margin never wraps.
    localparam int c_CMP_W = ((TH_W > ADDR_W + 1) ? TH_W : ADDR_W + 1) + 1;

    localparam logic [ADDR_W:0]    c_DEPTH     = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]    c_OCC_ONE   = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0]  c_PTR_ONE   = ADDR_W'(1);
    localparam logic [c_CMP_W-1:0] c_DEPTH_CMP = c_CMP_W'(DEPTH);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_PAUSED = 1'b1
    } state_t;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_occ;
    logic [DATA_W-1:0] r_data_out;
    logic              r_valid;
    logic              r_error;
    logic              r_cont;
    state_t            r_state;

    logic              w_empty;
    logic              w_full;
    logic              w_pop_ok;
    logic              w_push_ok;
    logic              w_err_set;
    logic [ADDR_W:0]   w_occ_next;
    logic [c_CMP_W-1:0] w_occ_ext;
    logic              w_go_pause;
    logic              w_go_run;
    state_t            w_state_next;
    logic              w_cont_next;

    assign w_empty   = (r_occ == '0);
    assign w_full    = (r_occ == c_DEPTH);
    assign w_pop_ok  = pop & ~w_empty;
    assign w_push_ok = push & (~w_full | w_pop_ok);
    assign w_err_set = (push & ~w_push_ok) | (pop & w_empty);

    always_comb begin
        w_occ_next = r_occ;
        case ({w_push_ok, w_pop_ok})
            2'b10:   w_occ_next = r_occ + c_OCC_ONE;
            2'b01:   w_occ_next = r_occ - c_OCC_ONE;
            default: w_occ_next = r_occ;
        endcase
    end

    // PAUSE when the remaining room drops to the margin: occ + th >= DEPTH.
    assign w_occ_ext  = c_CMP_W'(w_occ_next);
    assign w_go_pause = (w_occ_ext + c_CMP_W'(almost_full_th)) >= c_DEPTH_CMP;
    assign w_go_run   = w_occ_ext <= c_CMP_W'(almost_empty_th);

    always_comb begin
        w_state_next = r_state;
        w_cont_next  = 1'b0;
        case (r_state)
            ST_RUN: begin
                if (w_go_pause) begin
                    w_state_next = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                // A simultaneous pause condition keeps the FIFO paused.
                if (!w_go_pause && w_go_run) begin
                    w_state_next = ST_RUN;
                    w_cont_next  = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_RUN;
            r_cont  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_cont  <= w_cont_next;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_occ      <= '0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_occ   <= w_occ_next;
            r_valid <= w_pop_ok;
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop_ok) begin
                r_rd_ptr   <= r_rd_ptr + c_PTR_ONE;
                r_data_out <= r_mem[r_rd_ptr];
            end
        end
    end

    // Storage carries no reset; its contents are qualified by the pointers.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_error <= 1'b0;
        end else begin
`ifdef FIFO_ERR_CLR_EN
            r_error <= w_err_set | (r_error & ~err_clr);
`else
            r_error <= w_err_set | r_error;
`endif
        end
    end

    assign data_out   = r_data_out;
    assign valid_out  = r_valid;
    assign fifo_empty = w_empty;
    assign fifo_full  = w_full;
    assign pause      = (r_state == ST_PAUSED);
    assign continue_o = r_cont;
    assign fifo_error = r_error;
    assign occupancy  = r_occ;

endmodule

`default_nettype wire

// File: doc/fifo_flow_ctrl_param.md
Name: fifo_flow_ctrl_param

Overview:
Parametrised synchronous FIFO with programmable almost-empty/almost-full thresholds and a hysteretic PAUSE/CONTINUE flow-control FSM for the upstream sender. It has a sticky error flag for overflow and underflow, and a registered read port with valid_out. It sits between a producer that honours pause and a consumer that pops at will. It generalises the fixed 6-bit x 8-entry FIFO in width, depth and threshold width.

Parameters:
DATA_W, 6, data word width in bits.
DEPTH, 8, number of entries; power of two, at least 4.
ADDR_W, 3, log2(DEPTH); the integrator sets it consistently with DEPTH.
TH_W, 4, width of the threshold inputs; must satisfy 2^TH_W > DEPTH-1.

Ports:
clk  in  1  single clock; all state updates on its rising edge.
reset_L  in  1  asynchronous, active-low reset.
push  in  1  write request; accepted when not full, or when full and an accepted pop occurs in the same cycle.
pop  in  1  read request; accepted when not empty.
data_in  in  DATA_W  write data, sampled on an accepted push.
almost_empty_th  in  TH_W  CONTINUE threshold, in entries; static while out of reset.
almost_full_th  in  TH_W  PAUSE margin, in entries below DEPTH; static while out of reset.
data_out  out  DATA_W  registered read data.
valid_out  out  1  high for one cycle when data_out carries a popped word.
fifo_empty  out  1  occupancy == 0.
fifo_full  out  1  occupancy == DEPTH.
pause  out  1  request that upstream stop pushing (level).
continue_o  out  1  one-cycle pulse when pause deasserts.
fifo_error  out  1  sticky overflow/underflow flag.
occupancy  out  ADDR_W+1  current entry count.

Behaviour:
- Reset (asynchronous assert, release on the next clk edge):
  - Pointers and occupancy = 0; fifo_empty = 1; fifo_full = 0.
  - data_out = 0, valid_out = 0, pause = 0, continue_o = 0, fifo_error = 0; FSM = RUN.
  - Memory contents are don't-care.
- Storage and pointers:
  - Write and read pointers are ADDR_W bits and wrap modulo DEPTH.
  - occupancy is a registered counter: +1 on an accepted push only, -1 on an accepted pop only, unchanged on both or neither.
- Accept rules:
  - pop_ok = pop & ~fifo_empty.
  - push_ok = push & (~fifo_full | pop_ok).
  - Push and pop on an empty FIFO: only the push is accepted. There is no fall-through; the pop counts as an underflow.
  - Push and pop on a full FIFO: both accepted; occupancy stays at DEPTH; data order is preserved.
- Read latency is 1 cycle:
  - On an accepted pop at edge N, data_out holds mem[rd_ptr] and valid_out = 1 after edge N.
  - If no pop is accepted at the next edge, valid_out returns to 0 after it and data_out holds its last value.
- Errors:
  - push & ~push_ok (overflow) or pop & fifo_empty (underflow) sets fifo_error at that edge.
  - The offending operation is dropped: memory, pointers and occupancy are unchanged by it.
  - fifo_error stays set until reset.
- Flow-control FSM (states RUN, PAUSED), evaluated on occ_next, the occupancy after the current edge:
  - RUN -> PAUSED when occ_next >= DEPTH - almost_full_th.
  - PAUSED -> RUN when occ_next <= almost_empty_th; continue_o pulses for exactly one cycle on that transition.
  - In the band between the two thresholds the FSM holds its state (hysteresis).
  - pause = (state == PAUSED), registered, so it appears in the cycle after the triggering edge.
  - If both conditions hold at once (misprogrammed thresholds), PAUSED wins and no continue_o pulse is issued.
- pause is advisory only: pushes while paused are still accepted if there is space.
- Reset mid-operation: all state returns immediately to reset values. No valid_out or continue_o pulse follows the reset.

Optional Feature:
FIFO_ERR_CLR_EN
- Defined: adds input port err_clr (1 bit). When high at a clock edge, fifo_error is cleared. If an overflow or underflow occurs in that same cycle, the set wins and fifo_error = 1.
- Undefined: no err_clr port; fifo_error clears only on reset.

Test Plan:
- Reset: hold reset_L = 0 for 2 cycles, then release -> fifo_empty = 1, occupancy = 0, pause = 0, fifo_error = 0, valid_out = 0.
- Fill (DEPTH = 8, almost_full_th = 1, almost_empty_th = 3): push 0x01, 0x16, 0x30, 0x1C, 0x1D and three more words -> pause = 1 in the cycle after the 7th push; fifo_full = 1 after the 8th push; fifo_error = 0.
- Drain: 8 consecutive pops -> valid_out high for 8 cycles, data_out = 0x01, 0x16, 0x30, 0x1C, 0x1D, ... in push order. continue_o pulses once, in the cycle after occupancy reaches 3; pause = 0 from then on; fifo_empty = 1 at the end.
- Overflow/underflow:
  - 9th push while full -> fifo_error = 1, occupancy stays 8, contents intact.
  - After reset, pop on empty -> fifo_error = 1, valid_out = 0.
- Simultaneous operations:
  - Push + pop at full -> occupancy stays 8, oldest word appears on data_out, no error.
  - Push + pop at empty -> occupancy becomes 1, fifo_error = 1.
- Mid-operation reset: assert reset_L = 0 asynchronously with 5 entries and pause = 0 -> outputs return to reset values immediately. A push of 0x2A afterwards pops back as 0x2A.
